// File: rtl/regfile_mp.sv
// Multi-port register file: binary write port, N_RD registered read ports
// with write-first bypass, and a per-entry busy scoreboard.
module regfile_mp #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic [N_RD-1:0]          rd_en,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_valid,
    output logic [N_RD-1:0]          rd_busy,
    output logic [DEPTH*DATA_W-1:0]  regs_out,
    output logic [DEPTH-1:0]         busy_out,
    output logic                     err_oob
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0]      mem [DEPTH];
    logic [DEPTH-1:0]       busy;
    logic [DEPTH-1:0]       busy_nxt;
    logic                   wr_hit;
    logic                   al_hit;
    logic                   oob;
    logic [N_RD*DATA_W-1:0] rd_data_d;
    logic [N_RD-1:0]        rd_busy_d;
    logic [ADDR_W-1:0]      ra;

    function automatic logic in_rng(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Alloc is applied after the write so a same-entry pair leaves it busy.
    always_comb begin
        wr_hit   = we && in_rng(waddr) && !is_zero(waddr);
        al_hit   = alloc_en && in_rng(alloc_addr) && !is_zero(alloc_addr);
        oob      = (we && !in_rng(waddr)) ||
                   (alloc_en && !in_rng(alloc_addr));
        busy_nxt = busy;
        if (wr_hit) busy_nxt[waddr] = 1'b0;
        if (al_hit) busy_nxt[alloc_addr] = 1'b1;
    end

    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        ra        = '0;
        for (int k = 0; k < N_RD; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            if (in_rng(ra) && !is_zero(ra)) begin
                rd_data_d[k*DATA_W +: DATA_W] =
                    (wr_hit && ra == waddr) ? wdata : mem[ra];
                rd_busy_d[k] = busy_nxt[ra];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy     <= '0;
            rd_data  <= '0;
            rd_valid <= '0;
            rd_busy  <= '0;
            err_oob  <= 1'b0;
        end else begin
            if (wr_hit) mem[waddr] <= wdata;
            busy     <= busy_nxt;
            err_oob  <= err_oob | oob;
            rd_valid <= rd_en;
            for (int k = 0; k < N_RD; k++) begin
                if (rd_en[k]) begin
                    rd_data[k*DATA_W +: DATA_W] <=
                        rd_data_d[k*DATA_W +: DATA_W];
                    rd_busy[k] <= rd_busy_d[k];
                end
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        assign regs_out[i*DATA_W +: DATA_W] = mem[i];
    end

    assign busy_out = busy;

endmodule
